// File: rtl/mips_defs.sv
// Shared definitions for the MIPS32 fetch front end: reset vector, ROM
// geometry, the NOP encoding and the fetch state encoding.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          ROM_AW_DEF   = 14;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_t;

  // ROM words are stored little-endian; decode expects the reversed order.
  function automatic logic [31:0] byte_swap(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction and its PC,
// with clear (reset/flush) taking priority over hold (stall).
module if_id_reg
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst,
  input  logic        fetch_valid,
  input  logic        fetch_adel,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc    <= 32'h0000_0000;
      id_inst  <= NOP;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (!stall) begin
      id_pc    <= fetch_pc;
      id_inst  <= fetch_inst;
      id_valid <= fetch_valid;
      id_adel  <= fetch_adel;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, boot FSM, synchronous ROM
// addressing and the IF/ID register feeding decode.
module if_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          ROM_AW    = ROM_AW_DEF,
  parameter bit          BYTE_SWAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       new_pc,
  input  logic              branch_flag,
  input  logic [31:0]       branch_target,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       pc,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_inst,
  output logic              id_valid,
  output logic              id_adel
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc_next;
  logic [31:0]  fetch_inst;
  logic         fetch_valid;
  logic         fetch_adel;

  // One boot cycle lets the ROM latch the reset vector before pc advances.
  always_comb begin
    state_next = state;
    if (rst) begin
      state_next = S_BOOT;
    end else if (state == S_BOOT) begin
      state_next = S_RUN;
    end
  end

  always_comb begin
    pc_next = pc + 32'd4;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (flush) begin
      pc_next = new_pc;
    end else if (state == S_BOOT || stall) begin
      pc_next = pc;
    end else if (branch_flag) begin
      pc_next = branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= S_BOOT;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  // ROM is addressed with pc_next so its data lines up with pc on the same edge.
  assign rom_ce   = ~rst;
  assign rom_addr = pc_next[ROM_AW+1:2];

  always_comb begin
    fetch_valid = (state == S_RUN);
    fetch_adel  = (pc[1:0] != 2'b00) && (state == S_RUN);
    fetch_inst  = BYTE_SWAP ? byte_swap(rom_data) : rom_data;
    if (fetch_adel) begin
      fetch_inst = NOP;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall       (stall),
    .fetch_pc    (pc),
    .fetch_inst  (fetch_inst),
    .fetch_valid (fetch_valid),
    .fetch_adel  (fetch_adel),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .id_adel     (id_adel)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed control vectors push expected
// IF/ID contents; a monitor pops and compares whenever decode gets a new instruction.
module tb_if_stage;

  localparam int ROM_AW = 14;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              branch_flag;
  logic [31:0]       branch_target;
  logic              rom_ce;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [31:0]       pc;
  logic [31:0]       id_pc;
  logic [31:0]       id_inst;
  logic              id_valid;
  logic              id_adel;

  logic [31:0] mem [0:(1<<ROM_AW)-1];
  exp_t        exp_q[$];
  int          total;
  int          bad;

  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        hold_adel;
  logic        hold_valid;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .ROM_AW    (ROM_AW),
    .BYTE_SWAP (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .pc            (pc),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid),
    .id_adel       (id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle latency, zero output when not enabled.
  always @(posedge clk) begin
    rom_data <= rom_ce ? mem[rom_addr] : 32'h0000_0000;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  task automatic expectIssue(input logic [31:0] epc, input logic [31:0] einst, input logic eadel);
    exp_t e;
    e.pc   = epc;
    e.inst = einst;
    e.adel = eadel;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic fl, input logic br,
                               input logic [31:0] bt, input logic [31:0] np);
    @(negedge clk);
    rst           = r;
    stall         = st;
    flush         = fl;
    branch_flag   = br;
    branch_target = bt;
    new_pc        = np;
    @(posedge clk);
    #1;
  endtask

  // Monitor: judges each edge by the control inputs that were applied at it.
  always @(posedge clk) begin
    logic a_rst;
    logic a_st;
    logic a_fl;
    exp_t e;
    a_rst = rst;
    a_st  = stall;
    a_fl  = flush;
    #1;
    if (a_rst || a_fl) begin
      checkOutput("mon_cleared_valid", {31'b0, id_valid}, 32'd0);
      hold_valid = 1'b0;
    end else if (a_st) begin
      checkOutput("mon_stall_valid", {31'b0, id_valid}, {31'b0, hold_valid});
      if (hold_valid) begin
        checkOutput("mon_stall_pc", id_pc, hold_pc);
        checkOutput("mon_stall_inst", id_inst, hold_inst);
        checkOutput("mon_stall_adel", {31'b0, id_adel}, {31'b0, hold_adel});
      end
    end else if (id_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("mon_unexpected_issue_pc", id_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("mon_id_pc", id_pc, e.pc);
        checkOutput("mon_id_inst", id_inst, e.inst);
        checkOutput("mon_id_adel", {31'b0, id_adel}, {31'b0, e.adel});
        hold_pc    = e.pc;
        hold_inst  = e.inst;
        hold_adel  = e.adel;
        hold_valid = 1'b1;
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total         = 0;
    bad           = 0;
    hold_valid    = 1'b0;
    hold_pc       = 32'h0;
    hold_inst     = 32'h0;
    hold_adel     = 1'b0;
    rst           = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    new_pc        = 32'h0;
    for (int i = 0; i < (1 << ROM_AW); i++) mem[i] = 32'h0;
    mem[0]   = 32'h0060_8640;
    mem[1]   = 32'h0068_8040;
    mem[2]   = 32'h1122_3344;
    mem[3]   = 32'h5566_7788;
    mem[64]  = 32'hDEAD_BEEF;
    mem[65]  = 32'h0102_0304;
    mem[192] = 32'hCAFE_F00D;
    mem[193] = 32'h0BAD_F00D;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_id_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("reset_id_pc", id_pc, 32'h0);
    checkOutput("reset_id_inst", id_inst, 32'h0);
    checkOutput("reset_id_adel", {31'b0, id_adel}, 32'd0);
    checkOutput("reset_rom_ce", {31'b0, rom_ce}, 32'd0);

    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("boot_pc", pc, 32'h0);
    checkOutput("boot_rom_ce", {31'b0, rom_ce}, 32'd1);
    checkOutput("boot_id_valid", {31'b0, id_valid}, 32'd0);

    expectIssue(32'h0, 32'h4086_6000, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("run_pc4", pc, 32'h4);
    expectIssue(32'h4, 32'h4080_6800, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("run_pc8", pc, 32'h8);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0, 32'h0);
      checkOutput("stall_pc", pc, 32'h8);
      checkOutput("stall_rom_ce", {31'b0, rom_ce}, 32'd1);
    end

    expectIssue(32'h8, 32'h4433_2211, 1'b0);
    applyStimulus(0, 0, 0, 1, 32'h0000_0100, 32'h0);
    checkOutput("branch_pc", pc, 32'h100);
    expectIssue(32'h100, 32'hEFBE_ADDE, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("target_pc_next", pc, 32'h104);
    expectIssue(32'h104, 32'h0403_0201, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("seq_pc", pc, 32'h108);

    applyStimulus(0, 1, 1, 1, 32'h0000_0500, 32'h0000_0300);
    checkOutput("flush_pc", pc, 32'h300);
    checkOutput("flush_id_valid", {31'b0, id_valid}, 32'd0);

    expectIssue(32'h300, 32'h0DF0_FECA, 1'b0);
    applyStimulus(0, 0, 0, 1, 32'h0000_0102, 32'h0);
    checkOutput("misaligned_pc", pc, 32'h102);
    expectIssue(32'h102, 32'h0, 1'b1);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("adel_flag", {31'b0, id_adel}, 32'd1);
    checkOutput("adel_pc_next", pc, 32'h106);

    applyStimulus(1, 1, 1, 1, 32'h0000_0500, 32'h0000_0300);
    checkOutput("rerst_pc", pc, 32'h0);
    checkOutput("rerst_id_pc", id_pc, 32'h0);
    checkOutput("rerst_id_inst", id_inst, 32'h0);
    checkOutput("rerst_id_adel", {31'b0, id_adel}, 32'd0);
    checkOutput("rerst_rom_ce", {31'b0, rom_ce}, 32'd0);

    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("reboot_pc", pc, 32'h0);
    checkOutput("reboot_id_valid", {31'b0, id_valid}, 32'd0);
    expectIssue(32'h0, 32'h4086_6000, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    expectIssue(32'h4, 32'h4080_6800, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("restart_pc", pc, 32'h8);

    @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS32 pipeline. Owns the program counter, drives the synchronous instruction ROM (one-cycle read latency, zero output when not enabled, little-endian byte order in storage), and presents fetched instructions to decode through the IF/ID pipeline register. Handles stall, delayed-branch redirect and exception/ERET flush from pipeline control.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- ROM_AW, 14, ROM word-address width; ROM word address = pc[ROM_AW+1:2]
- BYTE_SWAP, 1, 1 = reverse byte order of rom_data before issue

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  kill IF and IF/ID contents, redirect to new_pc
- new_pc  in  32  exception vector / EPC target
- branch_flag  in  1  redirect request from decode
- branch_target  in  32  branch/jump target
- rom_ce  out  1  ROM enable
- rom_addr  out  ROM_AW  ROM word address
- rom_data  in  32  ROM read data
- pc  out  32  current fetch PC
- id_pc  out  32  PC of instruction held in IF/ID
- id_inst  out  32  instruction held in IF/ID
- id_valid  out  1  IF/ID holds a real instruction
- id_adel  out  1  IF/ID instruction fetched from misaligned PC

## Operation
- States: S_BOOT, S_RUN. rst forces S_BOOT. S_BOOT with rst=0 moves to S_RUN after one cycle.
- pc_next priority: rst -> RESET_PC; flush -> new_pc; S_BOOT -> pc; stall -> pc; branch_flag -> branch_target; else pc+4 (wraps 32'hFFFF_FFFC -> 0).
- rom_addr = pc_next[ROM_AW+1:2] (combinational); rom_ce = ~rst. ROM and pc both update on the same edge, so rom_data always belongs to pc in S_RUN.
- Bits of pc above ROM_AW+1 ignored for addressing; no range check.
- IF/ID update each edge: rst or flush -> id_pc=0, id_inst=0, id_valid=0, id_adel=0; stall -> hold; else id_pc=pc, id_inst=swap(rom_data), id_valid=(state==S_RUN), id_adel=(pc[1:0]!=0) and S_RUN.
- Misaligned PC still fetched; id_inst forced to 0 when id_adel=1.
- Delay slot: branch_flag arrives while the delay-slot instruction is in IF; it issues normally, target fetched next.
- branch_flag during stall is ignored; decode holds it until stall drops.
- flush overrides stall and branch_flag in the same cycle.

## Timing
- Reset values: pc=RESET_PC, state=S_BOOT, id_pc=0, id_inst=0, id_valid=0, id_adel=0; rom_ce=0 while rst=1.
- First edge with rst=0 (E1): ROM latches RESET_PC, pc stays RESET_PC, state -> S_RUN. E2: id_pc=RESET_PC, id_valid=1.
- Steady state: one instruction per cycle; PC-to-id_inst latency 1 edge after pc update.
- Flush at edge F: pc=new_pc, IF/ID bubble after F; instruction at new_pc valid in IF/ID after F+1.
- Branch at edge B: pc=branch_target after B, reaches IF/ID after B+1.
- rst mid-run: next edge identical to power-on reset, regardless of stall/flush.

## Structure
- Shared package mips_defs: RESET_PC default, ROM_AW, NOP word 32'h0, state encoding S_BOOT/S_RUN.
- Sub-module if_id_reg: IF/ID pipeline register (pc, inst, valid, adel) with rst/flush/stall controls; PC logic and FSM stay in if_stage.

## Test plan
- Reset, ROM model preloaded with mem[0]=32'h00608640, mem[1]=32'h00688040 -> E2 id_pc=0, id_inst=32'h40866000, id_valid=1; E3 id_pc=4, id_inst=32'h40806800.
- stall high 3 cycles in steady state -> pc, id_pc, id_inst, id_valid unchanged; rom_ce stays 1; sequence resumes without skip or duplicate.
- branch_flag=1, branch_target=32'h0000_0100 when pc=8 -> id shows pc 8 (delay slot) then 32'h100 with mem[64] swapped.
- flush=1, new_pc=32'h0000_0300 together with stall=1 and branch_flag=1 -> next edge id_valid=0, pc=32'h300; following edge id_pc=32'h300, id_valid=1.
- branch_target=32'h0000_0102 -> id_adel=1, id_inst=0, id_valid=1.
- rst asserted mid-run for 1 cycle -> all outputs at reset values; fetch restarts at RESET_PC with one S_BOOT cycle.
